// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit between execute and a
// word-organised data memory. One request in flight at a time; results return
// as a single-cycle response pulse.
//
// Build option: LSU_MISALIGN_EN
//   defined   - accesses crossing a word boundary are split into two word
//               accesses (ACC1 then ACC2) and merged on load.
//   undefined - such accesses fault at accept; ACC2 and the high half of the
//               load buffer are not built.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; decodes faults on accept
// ACC1  | first (or only) word access at the word holding addr
// ACC2  | second word access at word 1 + 4 (split accesses only)
// RESP  | one-cycle response pulse with extended load data or error
module load_store_unit #(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC1 = 2'd1,
      ST_ACC2 = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [31:0] buf_lo_q, buf_lo_d;
`ifdef LSU_MISALIGN_EN
   logic        misalign_q, misalign_d;
   logic [31:0] buf_hi_q, buf_hi_d;
`endif

   logic        accept;
   logic [2:0]  req_size;
   logic        req_legal;
   logic [32:0] req_last;
   logic        req_misalign;
   logic        misalign_fault;
   logic        req_fault;

   logic [3:0]  size_mask;
   logic [4:0]  lane_shamt;
   logic [3:0]  acc1_be;
   logic [31:0] acc1_wdata;
   logic [31:0] word1_addr;
   logic [63:0] load_buf;
   logic [31:0] load_raw;
   logic [31:0] load_ext;
`ifdef LSU_MISALIGN_EN
   logic [7:0]  wide_be;
   logic [63:0] wide_wdata;
   logic [3:0]  acc2_be;
   logic [31:0] acc2_wdata;
`endif

   assign accept = req_valid && (state_q == ST_IDLE);

   // Decode size, legality, range and alignment of the incoming request.
   always_comb begin
      case (req_funct3[1:0])
         2'b00:   req_size = 3'd1;
         2'b01:   req_size = 3'd2;
         default: req_size = 3'd4;
      endcase
      case (req_funct3)
         3'b000, 3'b001, 3'b010: req_legal = 1'b1;
         3'b100, 3'b101:         req_legal = !req_we;
         default:                req_legal = 1'b0;
      endcase
      req_last     = {1'b0, req_addr} + {30'b0, req_size} - 33'd1;
      req_misalign = ({2'b00, req_addr[1:0]} + {1'b0, req_size}) > 4'd4;
      req_fault    = !req_legal || (req_last >= ADDR_LIMIT) || misalign_fault;
   end

`ifdef LSU_MISALIGN_EN
   assign misalign_fault = 1'b0;
`else
   assign misalign_fault = req_misalign;
`endif

   // Byte-lane placement of the latched request.
   always_comb begin
      case (funct3_q[1:0])
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
   end

   assign lane_shamt = {addr_q[1:0], 3'b000};
   assign word1_addr = {addr_q[31:2], 2'b00};

`ifdef LSU_MISALIGN_EN
   assign wide_be    = {4'b0000, size_mask} << addr_q[1:0];
   assign wide_wdata = {32'h0, wdata_q} << lane_shamt;
   assign acc1_be    = wide_be[3:0];
   assign acc2_be    = wide_be[7:4];
   assign acc1_wdata = wide_wdata[31:0];
   assign acc2_wdata = wide_wdata[63:32];
   assign load_buf   = {buf_hi_q, buf_lo_q};
`else
   assign acc1_be    = size_mask << addr_q[1:0];
   assign acc1_wdata = wdata_q << lane_shamt;
   assign load_buf   = {32'h0, buf_lo_q};
`endif

   assign load_raw = 32'(load_buf >> lane_shamt);

   // Sign- or zero-extend the aligned load bytes according to funct3.
   always_comb begin
      case (funct3_q)
         3'b000:  load_ext = {{24{load_raw[7]}}, load_raw[7:0]};
         3'b001:  load_ext = {{16{load_raw[15]}}, load_raw[15:0]};
         3'b100:  load_ext = {24'h0, load_raw[7:0]};
         3'b101:  load_ext = {16'h0, load_raw[15:0]};
         default: load_ext = load_raw;
      endcase
   end

   // Next-state and output decode; all outputs idle low by default.
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'h0;
      resp_err   = 1'b0;
      mem_addr   = 32'h0;
      mem_we     = 1'b0;
      mem_be     = 4'b0000;
      mem_wdata  = 32'h0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = req_fault ? ST_RESP : ST_ACC1;
            end
         end
         ST_ACC1: begin
            mem_addr  = word1_addr;
            mem_we    = we_q;
            mem_be    = acc1_be;
            mem_wdata = acc1_wdata;
`ifdef LSU_MISALIGN_EN
            state_d   = misalign_q ? ST_ACC2 : ST_RESP;
`else
            state_d   = ST_RESP;
`endif
         end
`ifdef LSU_MISALIGN_EN
         ST_ACC2: begin
            mem_addr  = word1_addr + 32'd4;
            mem_we    = we_q;
            mem_be    = acc2_be;
            mem_wdata = acc2_wdata;
            state_d   = ST_RESP;
         end
`endif
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (err_q || we_q) ? 32'h0 : load_ext;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request latch on accept and load-buffer capture during word accesses.
   always_comb begin
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      buf_lo_d = buf_lo_q;
`ifdef LSU_MISALIGN_EN
      misalign_d = misalign_q;
      buf_hi_d   = buf_hi_q;
`endif
      if (accept) begin
         we_d     = req_we;
         funct3_d = req_funct3;
         addr_d   = req_addr;
         wdata_d  = req_wdata;
         err_d    = req_fault;
`ifdef LSU_MISALIGN_EN
         misalign_d = req_misalign;
`endif
      end
      if (state_q == ST_ACC1) begin
         buf_lo_d = mem_rdata;
      end
`ifdef LSU_MISALIGN_EN
      if (state_q == ST_ACC2) begin
         buf_hi_d = mem_rdata;
      end
`endif
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         err_q    <= 1'b0;
         buf_lo_q <= 32'h0;
`ifdef LSU_MISALIGN_EN
         misalign_q <= 1'b0;
         buf_hi_q   <= 32'h0;
`endif
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         buf_lo_q <= buf_lo_d;
`ifdef LSU_MISALIGN_EN
         misalign_q <= misalign_d;
         buf_hi_q   <= buf_hi_d;
`endif
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-addressed reference memory predicts every
// access and response; one negedge process compares the DUT each cycle.
module tb_load_store_unit;

   localparam int MW = 256;
`ifdef LSU_MISALIGN_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   load_store_unit #(.MEM_WORDS(MW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Data memory seen by the DUT.
   logic        mem_init = 1'b1;
   logic [31:0] tb_mem [MW];
   assign mem_rdata = (mem_addr < 32'(4 * MW)) ? tb_mem[mem_addr[9:2]] : 32'h0;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int w = 0; w < MW; w++)
            for (int l = 0; l < 4; l++)
               tb_mem[w][8*l +: 8] <= 8'((4 * w + l) * 7 + 3);
      end else if (mem_we) begin
         for (int l = 0; l < 4; l++)
            if (mem_be[l]) tb_mem[mem_addr[9:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
      end
   end

   // Reference model state.
   logic [7:0]  ref_bytes [4 * MW];
   int          m_start = -1, m_acc1 = -1, m_acc2 = -1, m_resp = -1;
   logic        m_we = 1'b0, m_err = 1'b0;
   logic [31:0] m_rdata = 32'h0, m_a1 = 32'h0, m_a2 = 32'h0, m_wd1 = 32'h0, m_wd2 = 32'h0;
   logic [3:0]  m_be1 = 4'h0, m_be2 = 4'h0;
   int          acc_e = 0;

   int          total = 0, bad = 0;
   logic        chk_en = 1'b0;
   logic        got_resp = 1'b0, last_err = 1'b0;
   logic [31:0] last_rdata = 32'h0;
   int          resp_cyc = -1, we_cnt = 0, acc_cnt = 0;
   logic [3:0]  obs_be1 = 4'h0, obs_be2 = 4'h0;
   logic [31:0] obs_wd1 = 32'h0, obs_wd2 = 32'h0, obs_a1 = 32'h0, obs_a2 = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Predict the whole transaction from byte-level rules at the accept edge.
   task automatic model_accept(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int e);
      int          size, ba;
      bit          legal, mis, err;
      longint      last;
      logic [63:0] wide;
      logic [31:0] val;
      size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      last  = longint'({32'h0, a}) + size - 1;
      mis   = (int'(a[1:0]) + size) > 4;
      err   = !legal || (last >= 4 * MW) || (mis && !MIS_EN);
      m_start = e; m_we = we; m_err = err; m_rdata = 32'h0;
      m_acc1 = -1; m_acc2 = -1; m_be1 = 4'h0; m_be2 = 4'h0;
      wide  = {32'h0, wd} << (8 * a[1:0]);
      m_wd1 = wide[31:0]; m_wd2 = wide[63:32];
      m_a1  = {a[31:2], 2'b00}; m_a2 = m_a1 + 32'd4;
      if (err) begin
         m_resp = e;
      end else begin
         m_acc1 = e;
         if (mis) begin m_acc2 = e + 1; m_resp = e + 2; end
         else m_resp = e + 1;
         val = 32'h0;
         for (int i = 0; i < size; i++) begin
            ba = int'(a) + i;
            if (ba / 4 == int'(a) / 4) m_be1[ba % 4] = 1'b1;
            else m_be2[ba % 4] = 1'b1;
            val[8*i +: 8] = ref_bytes[ba];
         end
         if (!we) begin
            case (f3)
               3'd0:    m_rdata = {{24{val[7]}}, val[7:0]};
               3'd1:    m_rdata = {{16{val[15]}}, val[15:0]};
               3'd4:    m_rdata = {24'h0, val[7:0]};
               3'd5:    m_rdata = {16'h0, val[15:0]};
               default: m_rdata = val;
            endcase
         end
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin : cmp
      logic        busy, in1, in2;
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_be;
      if (mem_init)
         for (int b = 0; b < 4 * MW; b++) ref_bytes[b] = 8'(b * 7 + 3);
      if (chk_en) begin
         busy   = (cyc >= m_start) && (cyc <= m_resp);
         in1    = (cyc == m_acc1);
         in2    = (cyc == m_acc2);
         e_addr = in1 ? m_a1 : in2 ? m_a2 : 32'h0;
         e_be   = in1 ? m_be1 : in2 ? m_be2 : 4'h0;
         e_wd   = in1 ? m_wd1 : in2 ? m_wd2 : 32'h0;
         chk("req_ready", req_ready, !busy);
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_we", mem_we, (in1 || in2) && m_we);
         chk("mem_be", mem_be, e_be);
         chk("mem_wdata", mem_wdata, e_wd);
         chk("resp_valid", resp_valid, cyc == m_resp);
         chk("resp_rdata", resp_rdata, (cyc == m_resp) ? m_rdata : 32'h0);
         chk("resp_err", resp_err, (cyc == m_resp) && m_err);
         if (mem_we) we_cnt++;
         if (mem_be != 4'h0) acc_cnt++;
         if (in1) begin obs_be1 = mem_be; obs_wd1 = mem_wdata; obs_a1 = mem_addr; end
         if (in2) begin obs_be2 = mem_be; obs_wd2 = mem_wdata; obs_a2 = mem_addr; end
         if (resp_valid) begin
            got_resp = 1'b1; last_rdata = resp_rdata; last_err = resp_err; resp_cyc = cyc;
         end
         if ((in1 || in2) && m_we)
            for (int l = 0; l < 4; l++)
               if (e_be[l]) ref_bytes[int'(e_addr) + l] = e_wd[8*l +: 8];
      end
   end

   task automatic start_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk); #1;
      got_resp = 1'b0; we_cnt = 0; acc_cnt = 0; resp_cyc = -1;
      obs_be1 = 4'h0; obs_be2 = 4'h0; obs_wd1 = 32'h0; obs_wd2 = 32'h0;
      obs_a1 = 32'h0; obs_a2 = 32'h0;
      acc_e = cyc;
      model_accept(we, f3, a, wd, cyc);
   endtask

   // One request; junk is held on the request port while the unit is busy.
   task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd);
      start_req(we, f3, a, wd);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'hFFFF_FFFF;
      while (cyc < m_resp) begin @(posedge clk); #1; end
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("resp_seen", got_resp, 1'b1);
   endtask

   // Latency in cycles counted from the accept edge (accept edge = T).
   function automatic int lat();
      return resp_cyc - acc_e + 1;
   endfunction

   task automatic op_rst(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
      start_req(we, f3, a, wd);
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      m_acc2 = -1; m_resp = -1; m_start = -1;
      rst = 1'b0;
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_resp_valid", resp_valid, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_resp", got_resp, 1'b0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_resp_valid0", resp_valid, 1'b0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_resp_err", resp_err, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_be", mem_be, 4'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      mem_init = 1'b0;
      rst = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); #1;

      op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
      chk("sw10_be", obs_be1, 4'b1111);
      chk("sw10_lat", lat(), 2);
      op(1'b0, 3'b010, 32'h10, 32'h0);
      chk("lw10_data", last_rdata, 32'hDEAD_BEEF);
      chk("lw10_lat", lat(), 2);

      op(1'b1, 3'b000, 32'h13, 32'h0000_0080);
      chk("sb13_be", obs_be1, 4'b1000);
      chk("sb13_wdata", obs_wd1, 32'h8000_0000);
      op(1'b0, 3'b000, 32'h13, 32'h0);
      chk("lb13", last_rdata, 32'hFFFF_FF80);
      op(1'b0, 3'b100, 32'h13, 32'h0);
      chk("lbu13", last_rdata, 32'h0000_0080);
      op(1'b0, 3'b010, 32'h10, 32'h0);
      chk("lw10_merged", last_rdata, 32'h80AD_BEEF);

      op(1'b1, 3'b001, 32'h22, 32'h0000_8001);
      chk("sh22_be", obs_be1, 4'b1100);
      chk("sh22_wdata", obs_wd1, 32'h8001_0000);
      op(1'b0, 3'b001, 32'h22, 32'h0);
      chk("lh22", last_rdata, 32'hFFFF_8001);
      op(1'b0, 3'b101, 32'h22, 32'h0);
      chk("lhu22", last_rdata, 32'h0000_8001);

      op(1'b0, 3'b010, 32'h3FC, 32'h0);
      chk("lw3fc", last_rdata, 32'hFCF5_EEE7);
      chk("lw3fc_err", last_err, 1'b0);
      op(1'b0, 3'b101, 32'h3FE, 32'h0);
      chk("lhu3fe", last_rdata, 32'h0000_FCF5);
      op(1'b0, 3'b010, 32'h400, 32'h0);
      chk("lw400_err", last_err, 1'b1);
      chk("lw400_noacc", acc_cnt, 0);
      chk("lw400_lat", lat(), 1);
      op(1'b0, 3'b001, 32'h3FF, 32'h0);
      chk("lh3ff_err", last_err, 1'b1);
      chk("lh3ff_noacc", acc_cnt, 0);
      op(1'b1, 3'b011, 32'h40, 32'h1234_5678);
      chk("st_f3_011_err", last_err, 1'b1);
      chk("st_f3_011_nowe", we_cnt, 0);
      op(1'b0, 3'b110, 32'h40, 32'h0);
      chk("ld_f3_110_err", last_err, 1'b1);

`ifdef LSU_MISALIGN_EN
      op(1'b1, 3'b010, 32'h0E, 32'h1122_3344);
      chk("sw0e_a1", obs_a1, 32'h0C);
      chk("sw0e_be1", obs_be1, 4'b1100);
      chk("sw0e_wd1", obs_wd1, 32'h3344_0000);
      chk("sw0e_a2", obs_a2, 32'h10);
      chk("sw0e_be2", obs_be2, 4'b0011);
      chk("sw0e_wd2", obs_wd2, 32'h0000_1122);
      op(1'b0, 3'b010, 32'h0E, 32'h0);
      chk("lw0e", last_rdata, 32'h1122_3344);
      chk("lw0e_lat", lat(), 3);
      op(1'b0, 3'b001, 32'h03, 32'h0);
      chk("lh03_split", last_rdata, 32'h0000_1F18);
      op_rst(1'b1, 3'b010, 32'h2E, 32'hAABB_CCDD);
      op(1'b0, 3'b010, 32'h2C, 32'h0);
      chk("rst_word1", last_rdata, 32'hCCDD_3E37);
      op(1'b0, 3'b010, 32'h30, 32'h0);
      chk("rst_word2", last_rdata, 32'h6861_5A53);
`else
      op(1'b0, 3'b001, 32'h03, 32'h0);
      chk("lh03_err", last_err, 1'b1);
      chk("lh03_rdata", last_rdata, 32'h0);
      chk("lh03_lat", lat(), 1);
      chk("lh03_noacc", acc_cnt, 0);
      op(1'b1, 3'b010, 32'h0E, 32'h1122_3344);
      chk("sw0e_err", last_err, 1'b1);
      chk("sw0e_nowe", we_cnt, 0);
      op_rst(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D);
      op(1'b0, 3'b010, 32'h40, 32'h0);
      chk("rst_word1", last_rdata, 32'hCAFE_F00D);
      op(1'b0, 3'b010, 32'h30, 32'h0);
      chk("lw30", last_rdata, 32'h6861_5A53);
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
